// File: rtl/i2c_master_pkg.sv
// Shared definitions for the audio-codec I2C master: command encodings, FSM state
// constants and the helper that decides how SDA is driven at the start of a slot.
package i2c_master_pkg;

  localparam logic [1:0] I2C_OP_START = 2'd0;
  localparam logic [1:0] I2C_OP_STOP  = 2'd1;
  localparam logic [1:0] I2C_OP_WRITE = 2'd2;
  localparam logic [1:0] I2C_OP_READ  = 2'd3;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START_S = 3'd1;
  localparam logic [2:0] ST_STOP_S  = 3'd2;
  localparam logic [2:0] ST_BITS    = 3'd3;
  localparam logic [2:0] ST_ACK     = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  // SDA pull-down applied in Q0 of a slot (1 = pull low, 0 = release).
  function automatic logic q0_sda_oe(input logic [2:0] st, input logic [1:0] op,
                                     input logic [7:0] wdata, input logic [2:0] bit_idx,
                                     input logic nack);
    logic oe;
    oe = 1'b0;
    case (st)
      ST_STOP_S: oe = 1'b1;
      ST_BITS:   oe = (op == I2C_OP_WRITE) && !wdata[bit_idx];
      ST_ACK:    oe = (op == I2C_OP_READ) && !nack;
      default:   oe = 1'b0;
    endcase
    return oe;
  endfunction

endpackage

// File: rtl/i2c_sync2.sv
// Two-flop synchronizer for an asynchronous pad input; resets to the released
// (high) bus level.
module i2c_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/i2c_master.sv
// Byte-level I2C master (START / STOP / WRITE / READ) driving open-drain pads.
// Define I2C_CLK_STRETCH_EN to honour slave clock stretching during Q1 of each slot.
module i2c_master
  import i2c_master_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_wdata,
  input  logic       cmd_nack,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_di,
  input  logic       sda_di,
  output logic [2:0] dbg_state
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);

  logic [2:0]    state;
  logic [1:0]    q;
  logic [DW-1:0] div;
  logic          arm;
  logic [2:0]    bit_cnt;
  logic [1:0]    op_r;
  logic [7:0]    wdata_r;
  logic          nack_r;
  logic [7:0]    shreg;
  logic          ack_bit;
  logic          scl_s;
  logic          sda_s;
  logic          stretch_hold;

  i2c_sync2 u_scl_sync (.clk(clk), .reset(reset), .d(scl_di), .q(scl_s));
  i2c_sync2 u_sda_sync (.clk(clk), .reset(reset), .d(sda_di), .q(sda_s));

`ifdef I2C_CLK_STRETCH_EN
  assign stretch_hold = (q == 2'd1) && !scl_s;
`else
  logic unused_scl_s;
  assign unused_scl_s = scl_s;
  assign stretch_hold = 1'b0;
`endif

  // Handshake: a command transfers on a cycle where cmd_valid && cmd_ready; op,
  // wdata and nack are captured then. cmd_ready is high in IDLE and in the DONE
  // cycle (rsp_valid), so a new command may follow back-to-back.
  assign cmd_ready = (state == ST_IDLE) || (state == ST_DONE);
  assign busy      = !cmd_ready;
  assign rsp_valid = (state == ST_DONE);
  assign dbg_state = state;

  // The cycle after acceptance (arm) loads the divider and applies Q0 of the first slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      q         <= '0;
      div       <= '0;
      arm       <= 1'b0;
      bit_cnt   <= '0;
      op_r      <= I2C_OP_START;
      wdata_r   <= '0;
      nack_r    <= 1'b0;
      shreg     <= '0;
      ack_bit   <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      rsp_rdata <= '0;
      rsp_nack  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          if (cmd_valid) begin
            op_r    <= cmd_op;
            wdata_r <= cmd_wdata;
            nack_r  <= cmd_nack;
            arm     <= 1'b1;
            bit_cnt <= 3'd7;
            case (cmd_op)
              I2C_OP_START: state <= ST_START_S;
              I2C_OP_STOP:  state <= ST_STOP_S;
              default:      state <= ST_BITS;
            endcase
          end
        end
        ST_START_S, ST_STOP_S, ST_BITS, ST_ACK: begin
          if (arm) begin
            arm    <= 1'b0;
            div    <= DIV_LOAD;
            q      <= 2'd0;
            sda_oe <= q0_sda_oe(state, op_r, wdata_r, bit_cnt, nack_r);
          end else if (stretch_hold) begin
            div <= DIV_LOAD;
          end else if (div != '0) begin
            div <= div - DW'(1);
          end else begin
            div <= DIV_LOAD;
            q   <= q + 2'd1;
            case (q)
              2'd0: scl_oe <= 1'b0;
              2'd1: if (state == ST_START_S) sda_oe <= 1'b1;
              2'd2: begin
                if (state == ST_STOP_S) sda_oe <= 1'b0;
                else scl_oe <= 1'b1;
                if (state == ST_BITS) shreg <= {shreg[6:0], sda_s};
                if (state == ST_ACK) ack_bit <= sda_s;
              end
              default: begin
                // End of slot: move to the next slot and apply its Q0 on this edge.
                case (state)
                  ST_BITS: begin
                    if (bit_cnt == 3'd0) begin
                      state  <= ST_ACK;
                      sda_oe <= q0_sda_oe(ST_ACK, op_r, wdata_r, bit_cnt, nack_r);
                    end else begin
                      bit_cnt <= bit_cnt - 3'd1;
                      sda_oe  <= q0_sda_oe(ST_BITS, op_r, wdata_r, bit_cnt - 3'd1, nack_r);
                    end
                  end
                  ST_ACK: begin
                    state <= ST_DONE;
                    if (op_r == I2C_OP_READ) rsp_rdata <= shreg;
                    else rsp_nack <= ack_bit;
                  end
                  default: state <= ST_DONE;
                endcase
              end
            endcase
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Self-checking bench for i2c_master: pulled-up bus with a behavioural slave,
// bus monitors and a transaction-level model of latency and response values.
module tb_i2c_master;

  localparam int K = 4;
  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_READ  = 2'd3;
  localparam int SM_NONE = 0;
  localparam int SM_ACK  = 1;
  localparam int SM_READ = 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_wdata = 8'd0;
  logic       cmd_nack = 1'b0;
  logic       cmd_ready, rsp_valid, rsp_nack, busy, scl_oe, sda_oe;
  logic [7:0] rsp_rdata;
  logic [2:0] unused_dbg_state;

  logic scl_bus, sda_bus;
  logic slave_sda_low;
  logic slave_scl_low = 1'b0;
  assign scl_bus = !(scl_oe || slave_scl_low);
  assign sda_bus = !(sda_oe || slave_sda_low);

  i2c_master #(.CLK_DIV(K)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_wdata(cmd_wdata), .cmd_nack(cmd_nack),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
    .busy(busy), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .scl_di(scl_bus), .sda_di(sda_bus), .dbg_state(unused_dbg_state)
  );

  // model / slave state, owned by the stimulus process
  int         cmd_id = 0;
  int         slave_mode = SM_NONE;
  logic [7:0] slave_byte = 8'd0;
  bit         stretch_en = 1'b0;
  logic [7:0] exp_rdata = 8'd0;
  logic       exp_nack = 1'b0;

  // bus watchers
  int   fall_id = -1, fall_cnt = 0, mon_id = -1, start_id = -1, stop_id = -1;
  int   rel_id = -1, rel_cnt = 0, slave_k;
  logic obs_q[$];

  int   n_checks = 0, n_fail = 0;
  int   cyc = 0;
  logic hist[$];

  always @(negedge scl_bus) begin
    if (fall_id != cmd_id) begin
      fall_id  = cmd_id;
      fall_cnt = 0;
    end
    fall_cnt++;
  end

  // Slave changes SDA only while SCL is low: ACK after 8 falls, read data before each rise.
  always_comb begin
    slave_sda_low = 1'b0;
    slave_k = (fall_id == cmd_id) ? fall_cnt : 0;
    case (slave_mode)
      SM_ACK:  slave_sda_low = (slave_k == 8);
      SM_READ: if (slave_k <= 7) slave_sda_low = !slave_byte[7 - slave_k];
      default: slave_sda_low = 1'b0;
    endcase
  end

  always @(posedge scl_bus) begin
    if (mon_id != cmd_id) begin
      mon_id = cmd_id;
      obs_q.delete();
    end
    obs_q.push_back(sda_bus);
  end

  always @(negedge sda_bus) if (scl_bus === 1'b1) start_id = cmd_id;
  always @(posedge sda_bus) if (scl_bus === 1'b1) stop_id = cmd_id;

  // Clock stretch: hold SCL low 20 cycles from the third SCL release of the command (bit 5).
  always @(negedge scl_oe) begin
    if (rel_id != cmd_id) begin
      rel_id  = cmd_id;
      rel_cnt = 0;
    end
    rel_cnt++;
    if (stretch_en && rel_cnt == 3) begin
      slave_scl_low = 1'b1;
      repeat (20) @(posedge clk);
      slave_scl_low = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    hist.push_back(sda_oe);
  endtask

  task automatic issue_cmd(input logic [1:0] op, input logic [7:0] wd, input logic nk,
                           input int smode, input logic [7:0] sbyte);
    @(negedge clk);
    cmd_id++;
    slave_mode = smode;
    slave_byte = sbyte;
    cmd_op = op;
    cmd_wdata = wd;
    cmd_nack = nk;
    cmd_valid = 1'b1;
    check("ready_at_issue", cmd_ready, 1);
    @(posedge clk);
    #1;
    cyc = 0;
    hist.delete();
    check("busy_after_accept", busy, 1);
    check("ready_after_accept", cmd_ready, 0);
    // garbage while busy must be ignored
    cmd_op = 2'($urandom);
    cmd_wdata = 8'($urandom);
    cmd_nack = 1'($urandom);
    repeat (3) step();
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] wd, input logic nk,
                         input int smode, input logic [7:0] sbyte, input bit check_bits);
    int lat, exp_lat, drv, nobs;
    logic [7:0] b;
    issue_cmd(op, wd, nk, smode, sbyte);
    while (!rsp_valid && cyc < 2000) step();
    check("rsp_timeout", rsp_valid, 1);
    lat = cyc;
    check("done_ready", cmd_ready, 1);
    check("done_busy", busy, 0);
    exp_lat = (op == OP_START || op == OP_STOP) ? 4 * K + 1 : 36 * K + 1;
`ifdef I2C_CLK_STRETCH_EN
    check("latency_min", 32'(lat >= exp_lat + (stretch_en ? 20 : 0)), 1);
`else
    check("latency", lat, exp_lat);
`endif
    case (op)
      OP_WRITE: exp_nack = (smode == SM_ACK) ? 1'b0 : 1'b1;
      OP_READ: begin
        exp_rdata = sbyte;
        drv = 0;
        for (int i = lat - 4 * K; i < lat; i++) drv += int'(hist[i - 1]);
        check("ack_slot_sda_oe_cycles", drv, nk ? 0 : 4 * K);
      end
      OP_START: check("start_condition", start_id, cmd_id);
      default: begin
        check("stop_condition", stop_id, cmd_id);
        check("stop_scl_oe", scl_oe, 0);
        check("stop_sda_oe", sda_oe, 0);
      end
    endcase
    if (check_bits && (op == OP_WRITE || op == OP_READ)) begin
      b = (op == OP_WRITE) ? wd : sbyte;
      nobs = (mon_id == cmd_id) ? obs_q.size() : 0;
      check("scl_rises", nobs, 9);
      if (nobs == 9) begin
        for (int i = 0; i < 8; i++) check($sformatf("sda_bit%0d", 7 - i), obs_q[i], b[7 - i]);
        check("ack_bit_on_bus", obs_q[8], (op == OP_WRITE) ? (smode != SM_ACK) : nk);
      end
    end
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_nack", rsp_nack, exp_nack);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, n;
    repeat (3) @(posedge clk);
    #1;
    check("reset_scl_oe", scl_oe, 0);
    check("reset_sda_oe", sda_oe, 0);
    check("reset_ready", cmd_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rdata", rsp_rdata, 0);
    check("reset_nack", rsp_nack, 0);
    @(negedge clk);
    reset = 1'b0;

    // directed sequence
    run_cmd(OP_START, 8'h00, 1'b0, SM_NONE, 8'h00, 1'b1);
    run_cmd(OP_WRITE, 8'h34, 1'b0, SM_ACK, 8'h00, 1'b1);
    run_cmd(OP_WRITE, 8'h34, 1'b0, SM_NONE, 8'h00, 1'b1);
    run_cmd(OP_READ, 8'h00, 1'b1, SM_READ, 8'hA5, 1'b1);
    run_cmd(OP_STOP, 8'h00, 1'b0, SM_NONE, 8'h00, 1'b1);

    // reset in the middle of bit 3 of a WRITE
    run_cmd(OP_START, 8'h00, 1'b0, SM_NONE, 8'h00, 1'b1);
    issue_cmd(OP_WRITE, 8'hC3, 1'b0, SM_ACK, 8'h00);
    while (cyc < 73) step();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_scl_oe", scl_oe, 0);
    check("midreset_sda_oe", sda_oe, 0);
    check("midreset_ready", cmd_ready, 1);
    check("midreset_busy", busy, 0);
    check("midreset_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    slave_mode = SM_NONE;
    exp_rdata = 8'h00;
    exp_nack = 1'b0;
    pulses = 0;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (rsp_valid) pulses++;
    end
    check("no_rsp_after_reset", pulses, 0);
    check("rdata_after_reset", rsp_rdata, exp_rdata);
    check("nack_after_reset", rsp_nack, exp_nack);

    // slave stretches SCL in bit 5
    run_cmd(OP_START, 8'h00, 1'b0, SM_NONE, 8'h00, 1'b1);
    stretch_en = 1'b1;
    run_cmd(OP_WRITE, 8'h5A, 1'b0, SM_NONE, 8'h00, 1'b0);
    stretch_en = 1'b0;
    run_cmd(OP_STOP, 8'h00, 1'b0, SM_NONE, 8'h00, 1'b1);

    // randomized transactions
    for (int t = 0; t < 12; t++) begin
      run_cmd(OP_START, 8'h00, 1'b0, SM_NONE, 8'h00, 1'b1);
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 1) == 1)
          run_cmd(OP_WRITE, 8'($urandom), 1'b0,
                  ($urandom_range(0, 1) == 1) ? SM_ACK : SM_NONE, 8'h00, 1'b1);
        else
          run_cmd(OP_READ, 8'h00, 1'($urandom_range(0, 1)), SM_READ, 8'($urandom), 1'b1);
      end
      run_cmd(OP_STOP, 8'h00, 1'b0, SM_NONE, 8'h00, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
